banco_reg_entrada_pico: RTL

- Parametrised successor of the 14-register PicoBlaze input bank.
- Holds N_REGS capture registers, each loaded from its own hardware source, plus a sticky event-flag register, an overrun register and an interrupt-mask register.
- Presents all of them to the PicoBlaze through a registered port_id read mux, and drives the PicoBlaze interrupt line.
- Sits between the RTC/keyboard front-ends and the PicoBlaze in_port.

---
 rtl/banco_pkg.sv | 23 ++
 rtl/reg_en_param.sv | 23 ++
 rtl/banco_reg_entrada_pico.sv | 133 +++++++++++++
 3 files changed

// File: rtl/banco_pkg.sv
// Shared constants for the PicoBlaze input register bank.
//   DEF_*_ADDR : default port_id map (capture block, sticky flags, overrun, mask)
//   FLG_*      : bit positions of the standard event sources in the flag register
//   addr_in_range : helper used by the elaboration-time address map check
package banco_pkg;

    localparam logic [7:0] DEF_BASE_ADDR = 8'h00;
    localparam logic [7:0] DEF_FLAG_ADDR = 8'hF0;
    localparam logic [7:0] DEF_OVR_ADDR  = 8'hF1;
    localparam logic [7:0] DEF_MASK_ADDR = 8'hF2;

    localparam int FLG_IRQ     = 0;
    localparam int FLG_READY   = 1;
    localparam int FLG_NEWDATA = 2;

    // True when addr falls inside [base, base+n-1].
    function automatic bit addr_in_range(input logic [7:0] addr,
                                         input logic [7:0] base,
                                         input int         n);
        return (int'(addr) >= int'(base)) && (int'(addr) <= int'(base) + n - 1);
    endfunction

endpackage

// File: rtl/reg_en_param.sv
// Generic DATA_W-wide register with load enable.
//   clk, rst_n : clock and asynchronous active-low reset (clears q)
//   en         : load enable
//   d          : load data
//   q          : register contents
module reg_en_param #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/banco_reg_entrada_pico.sv
// PicoBlaze input register bank: N_REGS capture registers, sticky event flags
// (clear-on-read), overrun flags (clear-on-read) and an interrupt mask, all
// readable through a registered port_id mux; drives the PicoBlaze interrupt.
//   clk, reset         : clock, asynchronous active-low reset
//   cap_en, cap_data   : per-register capture enable and data (slice i = reg i)
//   ev_in              : event level inputs, rising edges set the sticky flags
//   port_id, read_strobe, write_strobe, out_port : PicoBlaze I/O bus
//   in_port            : registered read data (valid one cycle after port_id)
//   interrupt          : registered |(flags & mask)
//   sal_flat, flags    : direct views of the capture registers and flags
module banco_reg_entrada_pico
    import banco_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         N_REGS    = 14,
    parameter int         N_FLAGS   = 3,
    parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [7:0] FLAG_ADDR = DEF_FLAG_ADDR,
    parameter logic [7:0] OVR_ADDR  = DEF_OVR_ADDR,
    parameter logic [7:0] MASK_ADDR = DEF_MASK_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REGS-1:0]        cap_en,
    input  logic [N_REGS*DATA_W-1:0] cap_data,
    input  logic [N_FLAGS-1:0]       ev_in,
    input  logic [7:0]               port_id,
    input  logic                     read_strobe,
    input  logic                     write_strobe,
    input  logic [DATA_W-1:0]        out_port,
    output logic [DATA_W-1:0]        in_port,
    output logic                     interrupt,
    output logic [N_REGS*DATA_W-1:0] sal_flat,
    output logic [N_FLAGS-1:0]       flags
);

    // ------------------------------------------------------------------
    // Address map sanity check at elaboration
    // ------------------------------------------------------------------
    localparam bit CFG_OK =
        (N_REGS >= 1) && (N_REGS <= 64) && (N_FLAGS >= 1) && (N_FLAGS <= DATA_W) &&
        (int'(BASE_ADDR) + N_REGS <= 256) &&
        (FLAG_ADDR != OVR_ADDR) && (FLAG_ADDR != MASK_ADDR) && (OVR_ADDR != MASK_ADDR) &&
        !addr_in_range(FLAG_ADDR, BASE_ADDR, N_REGS) &&
        !addr_in_range(OVR_ADDR,  BASE_ADDR, N_REGS) &&
        !addr_in_range(MASK_ADDR, BASE_ADDR, N_REGS);

    if (!CFG_OK) begin : g_cfg_error
        $error("banco_reg_entrada_pico: illegal parameter / address map configuration");
    end

    // ------------------------------------------------------------------
    // Capture registers: hardware capture beats a same-cycle software write
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        localparam logic [7:0] REG_ADDR = 8'(int'(BASE_ADDR) + i);

        logic              wr_hit;
        logic              ld_en;
        logic [DATA_W-1:0] ld_data;

        assign wr_hit  = write_strobe && (port_id == REG_ADDR);
        assign ld_en   = cap_en[i] | wr_hit;
        assign ld_data = cap_en[i] ? cap_data[i*DATA_W +: DATA_W] : out_port;

        reg_en_param #(.DATA_W(DATA_W)) u_reg (
            .clk   (clk),
            .rst_n (reset),
            .en    (ld_en),
            .d     (ld_data),
            .q     (sal_flat[i*DATA_W +: DATA_W])
        );
    end

    // ------------------------------------------------------------------
    // Flag / overrun / mask state
    // ------------------------------------------------------------------
    logic [N_FLAGS-1:0] ev_prev;
    logic [N_FLAGS-1:0] ovr;
    logic [N_FLAGS-1:0] mask;
    logic [N_FLAGS-1:0] ev_rise;
    logic [N_FLAGS-1:0] flag_clr;
    logic [N_FLAGS-1:0] ovr_clr;
    logic [N_FLAGS-1:0] ovr_set;
    logic               rd_flag;
    logic               rd_ovr;
    logic [DATA_W-1:0]  rd_data;

    assign ev_rise = ev_in & ~ev_prev;
    assign rd_flag = read_strobe && (port_id == FLAG_ADDR);
    assign rd_ovr  = read_strobe && (port_id == OVR_ADDR);

    // in_port holds exactly what software is receiving this cycle, so only
    // those bits are cleared; anything that arrived later stays pending.
    assign flag_clr = rd_flag ? in_port[N_FLAGS-1:0] : '0;
    assign ovr_clr  = rd_ovr  ? in_port[N_FLAGS-1:0] : '0;
    assign ovr_set  = ev_rise & flags & ~flag_clr;

    // ------------------------------------------------------------------
    // Read mux (registered below into in_port)
    // ------------------------------------------------------------------
    // NOTE: rd_data gets a default before any conditional assignment so the
    // combinational block can never infer a latch for unmapped addresses.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (port_id == 8'(int'(BASE_ADDR) + i)) rd_data = sal_flat[i*DATA_W +: DATA_W];
        end
        if (port_id == FLAG_ADDR) rd_data[N_FLAGS-1:0] = flags;
        if (port_id == OVR_ADDR)  rd_data[N_FLAGS-1:0] = ovr;
        if (port_id == MASK_ADDR) rd_data[N_FLAGS-1:0] = mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // All-ones history: a level already high at reset release is not an edge.
            ev_prev   <= '1;
            flags     <= '0;
            ovr       <= '0;
            mask      <= '0;
            in_port   <= '0;
            interrupt <= 1'b0;
        end else begin
            ev_prev   <= ev_in;
            flags     <= (flags & ~flag_clr) | ev_rise;
            ovr       <= (ovr & ~ovr_clr) | ovr_set;
            if (write_strobe && (port_id == MASK_ADDR)) mask <= out_port[N_FLAGS-1:0];
            in_port   <= rd_data;
            interrupt <= |(flags & mask);
        end
    end

endmodule
